// File: rtl/seq_mult_8x8.sv
// seq_mult_8x8: 8x8 unsigned shift-and-add multiplier, one lookahead-adder pass per cycle.
// AheadAdder_module is the 8-bit two-group carry-lookahead adder the multiplier iterates on.
module AheadAdder_module (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c0,
   output logic [7:0] f,
   output logic       c8
);
   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;
   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = c0;
   genvar n;
   for (n = 0; n < 2; n++) begin : grp
      localparam int lo = 4 * n;
      assign c[lo+1] = g[lo] | (p[lo] & c[lo]);
      assign c[lo+2] = g[lo+1] | (p[lo+1] & g[lo]) | (p[lo+1] & p[lo] & c[lo]);
      assign c[lo+3] = g[lo+2] | (p[lo+2] & g[lo+1]) | (p[lo+2] & p[lo+1] & g[lo])
                     | (p[lo+2] & p[lo+1] & p[lo] & c[lo]);
      assign c[lo+4] = g[lo+3] | (p[lo+3] & g[lo+2]) | (p[lo+3] & p[lo+2] & g[lo+1])
                     | (p[lo+3] & p[lo+2] & p[lo+1] & g[lo])
                     | (p[lo+3] & p[lo+2] & p[lo+1] & p[lo] & c[lo]);
   end
   assign f  = p ^ c[7:0];
   assign c8 = c[8];
endmodule

module seq_mult_8x8 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t     state, state_next;
   logic [7:0] a_reg, q_reg, m_reg, f;
   logic [2:0] cnt;
   logic       c8;
   AheadAdder_module u_add (
      .a (a_reg),
      .b (q_reg[0] ? m_reg : 8'h00),
      .c0(1'b0),
      .f (f),
      .c8(c8)
   );
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_next;
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (cnt == 3'd7) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end
   // The adder carry becomes A[7] after the shift, so it is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg   <= '0;
         q_reg   <= '0;
         m_reg   <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (state == IDLE && start) begin
         m_reg <= multiplicand;
         q_reg <= multiplier;
         a_reg <= '0;
         cnt   <= '0;
      end else if (state == CALC) begin
         a_reg <= {c8, f[7:1]};
         q_reg <= {f[0], q_reg[7:1]};
         cnt   <= cnt + 3'd1;
         if (cnt == 3'd7) product <= {c8, f, q_reg[7:1]};
      end
   end
   assign busy = state != IDLE;
   assign done = state == DONE;
endmodule

// File: tb/tb_seq_mult_8x8.sv
// tb_seq_mult_8x8: scoreboard bench; expected products queued at start, checked on done.
module tb_seq_mult_8x8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  multiplicand = 8'h00;
   logic [7:0]  multiplier = 8'h00;
   logic        busy, done;
   logic [15:0] product;
   logic [15:0] exp_q[$];
   logic [15:0] prev_product = 16'h0000;
   logic        rst_q = 1'b1;
   int          checks = 0;
   int          errors = 0;

   seq_mult_8x8 dut (
      .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
      .multiplier(multiplier), .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk) rst_q <= rst;

   // Every done must match the oldest queued product; otherwise product must hold.
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) check("spurious_done", 16'd0, 16'd1);
         else check("product", product, exp_q.pop_front());
      end else if (!rst_q) check("hold", product, prev_product);
      prev_product = product;
   end

   task automatic run_op(input logic [7:0] m, input logic [7:0] q, input bit inject);
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      exp_q.push_back({8'h00, m} * {8'h00, q});
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         check("busy", 16'(busy), 16'(i <= 8));
         check("done", 16'(done), 16'(i == 8));
         start = inject && i == 3;
         if (start) begin
            multiplicand = 8'hFF;
            multiplier   = 8'hFF;
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      check("rst_product", product, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'h0F, 8'h0F, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b0);
      run_op(8'h80, 8'h02, 1'b0);
      run_op(8'h00, 8'h5A, 1'b0);
      run_op(8'h5A, 8'h00, 1'b0);
      run_op(8'h12, 8'h34, 1'b1);
      // Abort an operation mid-flight; no done may follow it.
      @(negedge clk);
      multiplicand = 8'h55;
      multiplier   = 8'h55;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_done", 16'(done), 16'd0);
      check("abort_product", product, 16'h0000);
      repeat (12) @(posedge clk);
      run_op(8'h03, 8'h05, 1'b0);
      // Held start: operations must run back to back every 10 edges.
      @(negedge clk);
      multiplicand = 8'h07;
      multiplier   = 8'h09;
      start        = 1'b1;
      for (int n = 0; n < 3; n++) begin
         exp_q.push_back({8'h00, multiplicand} * {8'h00, multiplier});
         @(posedge clk);
         #1;
         check("b2b_accept", 16'(busy), 16'd1);
         repeat (8) @(posedge clk);
         #1;
         check("b2b_done", 16'(done), 16'd1);
         @(posedge clk);
         #1;
         check("b2b_idle", 16'(busy), 16'd0);
         if (n == 2) start = 1'b0;
      end
      for (int r = 0; r < 5; r++) run_op(8'($urandom), 8'($urandom), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
